// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, step count and FSM states.
package mips_pkg;

    localparam int WIDTH = 32;
    localparam int STEPS = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mult_div_sign.sv
// Conditional two's-complement negate; used as absolute value on operands and sign fix on results.
module mult_div_sign #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? ((~x) + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-step multiply / restoring divide unit with HI/LO result registers.
// Signed MULT/DIV are enabled by defining MULT_DIV_SIGNED_EN; otherwise they behave as MULTU/DIVU.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output state_t           dbg_state
);

    localparam int W = WIDTH;

    state_t         state;
    logic [5:0]     cnt;
    logic           is_div_q, sa_q, sb_q, div0_q;
    logic [W-1:0]   opnd_q;
    logic [2*W-1:0] p_q;

    logic           is_div_in, signed_in;
    logic [W-1:0]   mag_a, mag_b;

    assign is_div_in = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MULT_DIV_SIGNED_EN
    assign signed_in = (op == OP_MULT) || (op == OP_DIV);
`else
    assign signed_in = 1'b0;
`endif

    mult_div_sign #(.W(W)) u_abs_a (.x(a), .neg(signed_in & a[W-1]), .y(mag_a));
    mult_div_sign #(.W(W)) u_abs_b (.x(b), .neg(signed_in & b[W-1]), .y(mag_b));

    // p_q upper half is the partial product / remainder, lower half the multiplier / quotient.
    logic [W:0]     add_sum, shifted, diff;
    logic [2*W-1:0] mul_next, div_next;

    assign add_sum  = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    assign mul_next = {add_sum, p_q[W-1:1]};
    assign shifted  = {p_q[2*W-1:W], p_q[W-1]};
    assign diff     = shifted - {1'b0, opnd_q};
    assign div_next = diff[W] ? {shifted[W-1:0], p_q[W-2:0], 1'b0}
                              : {diff[W-1:0],    p_q[W-2:0], 1'b1};

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix, rem_fix;

    mult_div_sign #(.W(2*W)) u_fix_prod (.x(p_q),          .neg(sa_q ^ sb_q), .y(prod_fix));
    mult_div_sign #(.W(W))   u_fix_quot (.x(p_q[W-1:0]),   .neg(sa_q ^ sb_q), .y(quot_fix));
    mult_div_sign #(.W(W))   u_fix_rem  (.x(p_q[2*W-1:W]), .neg(sa_q),        .y(rem_fix));

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= 6'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            div0_q   <= 1'b0;
            opnd_q   <= '0;
            p_q      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        is_div_q <= is_div_in;
                        sa_q     <= signed_in & a[W-1];
                        sb_q     <= signed_in & b[W-1];
                        div0_q   <= is_div_in && (b == '0);
                        opnd_q   <= is_div_in ? mag_b : mag_a;
                        p_q      <= {{W{1'b0}}, (is_div_in ? mag_a : mag_b)};
                        cnt      <= 6'd0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt == 6'(STEPS)) begin
                        // Divide by zero leaves the dividend magnitude as remainder, which
                        // the remainder sign fix turns back into A.
                        if (is_div_q) begin
                            lo <= div0_q ? {W{1'b1}} : quot_fix;
                            hi <= rem_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        p_q <= is_div_q ? div_next : mul_next;
                        cnt <= cnt + 6'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit; expectations follow MULT_DIV_SIGNED_EN.
module tb_mult_div_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    state_t      dbg_state;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
    );

    // Clock / reset-independent bookkeeping
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    int unsigned exp_cyc_q[$];
    logic [31:0] last_hi = '0, last_lo = '0;
    logic        prev_done = 1'b0;
    logic [63:0] mon_e;
    int unsigned mon_c;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse pops one expected result
    always @(negedge clk) begin
        if (done) begin
            check("done_one_cycle", 64'(prev_done), 64'd0);
            check("busy_low_at_done", 64'(busy), 64'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no done (cycle %0d)", hi, lo, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("hi", 64'(hi), 64'(mon_e[63:32]));
                check("lo", 64'(lo), 64'(mon_e[31:0]));
                check("latency", 64'(cyc), 64'(mon_c));
                last_hi = mon_e[63:32];
                last_lo = mon_e[31:0];
            end
        end
        prev_done = done;
    end

    // Driver tasks
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] e);
        int t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: got busy=1 expected busy=0 within 200 cycles");
        end
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 34);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] e;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'd2,         64'h00000001_FFFFFFFE});
        vecs.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFFFFFE_00000001});
        vecs.push_back('{OP_MULTU, 32'd0,         32'd12345,     64'h00000000_00000000});
        vecs.push_back('{OP_DIVU,  32'd100,       32'd0,         64'h00000064_FFFFFFFF});
        vecs.push_back('{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         64'h00000000_FFFFFFFF});
        vecs.push_back('{OP_DIV,   32'hFFFF_FFF8, 32'd0,         64'hFFFFFFF8_FFFFFFFF});
        vecs.push_back('{OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000});
`ifdef MULT_DIV_SIGNED_EN
        vecs.push_back('{OP_MULT,  32'hFFFF_FFFD, 32'd5,         64'hFFFFFFFF_FFFFFFF1});
        vecs.push_back('{OP_MULT,  32'd7,         32'hFFFF_FFFF, 64'hFFFFFFFF_FFFFFFF9});
        vecs.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFFFFFF_FFFFFFFD});
        vecs.push_back('{OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h00000001_FFFFFFFD});
        vecs.push_back('{OP_DIV,   32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFFFFFE_0000000E});
        vecs.push_back('{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000});
`else
        vecs.push_back('{OP_MULT,  32'hFFFF_FFFD, 32'd5,         64'h00000004_FFFFFFF1});
        vecs.push_back('{OP_MULT,  32'd7,         32'hFFFF_FFFF, 64'h00000006_FFFFFFF9});
        vecs.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'h00000001_7FFFFFFC});
        vecs.push_back('{OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h00000007_00000000});
        vecs.push_back('{OP_DIV,   32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFFFF9C_00000000});
        vecs.push_back('{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000});
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back directed vectors; each start lands in the previous done cycle
        foreach (vecs[i]) issue(vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].e);
        drain();

        // Results hold while idle
        repeat (5) @(negedge clk);
        check("hold_hi_idle", 64'(hi), 64'(last_hi));
        check("hold_lo_idle", 64'(lo), 64'(last_lo));

        // Start while busy is ignored; results hold mid-operation
        issue(OP_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E);
        repeat (8) @(negedge clk);
        check("hold_hi_busy", 64'(hi), 64'(last_hi));
        check("hold_lo_busy", 64'(lo), 64'(last_lo));
        op = OP_MULTU;
        a = 32'd50;
        b = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_during_op", 64'(busy), 64'd1);
        drain();
        repeat (40) @(negedge clk);

        // Reset mid-operation aborts with no done
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFFFFFE_00000001);
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_cyc_q.delete();
        last_hi = '0;
        last_lo = '0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_done_state", 64'(dbg_state), 64'(ST_IDLE));
        issue(OP_MULTU, 32'd6, 32'd7, 64'h00000000_0000002A);
        drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO width; the design SHALL support only 32.
REQ-002 Clock  input  1  rising-edge clock; the unit SHALL use one clock only.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  request pulse; sampled only when Busy=0.
REQ-005 Op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 A  input  32  multiplicand or dividend (rs).
REQ-007 B  input  32  multiplier or divisor (rt).
REQ-008 Busy  output  1  high while an operation is in progress.
REQ-009 Done  output  1  one-cycle pulse when the result is written.
REQ-010 Hi  output  32  HI register (product[63:32] or remainder); feeds the writeback select mux.
REQ-011 Lo  output  32  LO register (product[31:0] or quotient); feeds the writeback select mux.

Function
REQ-012 Start=1 with Busy=0 at clock edge k SHALL capture Op, A and B, and SHALL set Busy=1 from edge k+1.
REQ-013 The iterative engine SHALL perform one shift-add (multiply) or one restoring subtract (divide) step per cycle, for 32 steps.
REQ-014 At edge k+33 the unit SHALL:
- load Hi and Lo;
- drive Done=1 for exactly one cycle;
- drive Busy=0.
REQ-015 Start while Busy=1 SHALL be ignored, with no effect on the operation in progress or on its result.
REQ-016 Start in the same cycle as Done SHALL be accepted; the next operation begins from edge k+34.
REQ-017 Hi and Lo SHALL hold their values between operations and SHALL change only at Done.
REQ-018 MULT/MULTU: {Hi,Lo} SHALL equal the exact 64-bit signed or unsigned product of A and B.
REQ-019 DIV/DIVU: Lo SHALL be the quotient and Hi the remainder.
REQ-020 Signed divide SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-021 Signed operations SHALL work on operand magnitudes and apply sign correction in the final step; the 32-step latency is unchanged.
REQ-022 Divide by zero SHALL give Lo=32'hFFFFFFFF and Hi=A, with the same 33-cycle latency.
REQ-023 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give Lo=32'h80000000 and Hi=0.

Reset
REQ-024 Reset_n=0 SHALL asynchronously clear Busy, Done, Hi, Lo, the step counter and all datapath registers to 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation, and no Done SHALL follow.
REQ-026 After reset is released, the first Start SHALL be accepted normally.

Configuration
REQ-027 Macro MULT_DIV_SIGNED_EN defined: MULT and DIV SHALL execute as signed operations per REQ-018 to REQ-023.
REQ-028 Macro MULT_DIV_SIGNED_EN undefined: MULT and DIV SHALL execute as MULTU and DIVU, the sign-correction logic SHALL be absent, and latency SHALL be unchanged.

Structure
REQ-029 The Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the step count constant (32) SHALL reside in the shared package mips_pkg.
REQ-030 Absolute-value and negate logic SHALL be one sub-module, mult_div_sign, instantiated for the operands and for the results.
REQ-031 The control logic SHALL be a 2-state FSM (IDLE, RUN) plus a 6-bit step counter.

Verification
REQ-032 MULTU A=32'hFFFFFFFF, B=2 -> after 33 cycles Hi=1, Lo=32'hFFFFFFFE, one Done pulse.
REQ-033 MULT A=-3, B=5 (macro defined) -> Hi=32'hFFFFFFFF, Lo=32'hFFFFFFF1; with the macro undefined -> Hi=4, Lo=32'hFFFFFFF1.
REQ-034 DIV A=-7, B=2 -> Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF; DIVU A=100, B=0 -> Lo=32'hFFFFFFFF, Hi=32'h64.
REQ-035 DIVU A=100, B=7, followed by a Start with new operands at cycle 10 -> the second Start is ignored, Lo=14, Hi=2, one Done pulse.
REQ-036 Reset_n pulsed low at cycle 15 of a MULTU -> Busy=0, Hi=Lo=0, no Done; a following MULTU A=6, B=7 -> Lo=42.
